// File: rtl/strip_width_writeback_if.sv
// Upstream-facing bundle of the strip occupancy writeback stage:
// placement results, clear request, occupancy reads and event outputs.
interface strip_width_writeback_if;
  logic       valid_in;
  logic [3:0] min_occupied_strip_id;
  logic [7:0] min_occupied_strip_width;
  logic       strike_flag;
  logic [7:0] new_occupied_strip_width;
  logic       clear_req;
  logic [3:0] rd_id_1;
  logic [3:0] rd_id_2;
  logic [3:0] rd_id_3;
  logic [7:0] rd_width_1;
  logic [7:0] rd_width_2;
  logic [7:0] rd_width_3;
  logic       ready;
  logic       place_valid;
  logic [3:0] place_strip_id;
  logic [7:0] place_x;
  logic       strike_valid;
  logic [7:0] strike_count;
  logic       err_flag;

  modport master (
    output valid_in,
    output min_occupied_strip_id,
    output min_occupied_strip_width,
    output strike_flag,
    output new_occupied_strip_width,
    output clear_req,
    output rd_id_1,
    output rd_id_2,
    output rd_id_3,
    input  rd_width_1,
    input  rd_width_2,
    input  rd_width_3,
    input  ready,
    input  place_valid,
    input  place_strip_id,
    input  place_x,
    input  strike_valid,
    input  strike_count,
    input  err_flag
  );

  modport slave (
    input  valid_in,
    input  min_occupied_strip_id,
    input  min_occupied_strip_width,
    input  strike_flag,
    input  new_occupied_strip_width,
    input  clear_req,
    input  rd_id_1,
    input  rd_id_2,
    input  rd_id_3,
    output rd_width_1,
    output rd_width_2,
    output rd_width_3,
    output ready,
    output place_valid,
    output place_strip_id,
    output place_x,
    output strike_valid,
    output strike_count,
    output err_flag
  );
endinterface

// File: rtl/strip_width_writeback.sv
// Strip occupancy table with placement writeback, strike counting,
// a RUN/CLEAR sweep FSM and three bypassed combinational read ports.
module strip_width_writeback #(
  parameter int NUM_STRIPS = 13,
  parameter int STRIP_W    = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  strip_width_writeback_if.slave bus
);

  // Ids and widths are 4 and 8 bits wide on the bus.
  if (NUM_STRIPS < 1 || NUM_STRIPS > 16 || STRIP_W > 255) begin : g_bad_cfg
    $error("strip_width_writeback: unsupported configuration");
  end

  typedef enum logic {RUN, CLEAR} state_t;

  localparam logic [3:0] LAST = 4'(NUM_STRIPS - 1);

  state_t     state;
  state_t     nxt;
  logic [3:0] idx;
  logic [7:0] tbl [NUM_STRIPS];

  logic id_ok;
  logic run;
  logic wr_en;
  logic st_en;
  logic drop;

  assign id_ok = bus.min_occupied_strip_id <= LAST;
  assign run   = state == RUN;
  assign wr_en = bus.valid_in && run && !bus.strike_flag && id_ok;
  assign st_en = bus.valid_in && run && bus.strike_flag && id_ok;
  assign drop  = bus.valid_in && (!id_ok || !run);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= nxt;
  end

  // FSM next state: clear requests only count in RUN.
  always_comb begin
    nxt = state;
    unique case (state)
      RUN:   if (bus.clear_req) nxt = CLEAR;
      CLEAR: if (idx == LAST)   nxt = RUN;
      default: nxt = RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.ready = 1'b0;
    unique case (state)
      RUN:     bus.ready = 1'b1;
      CLEAR:   bus.ready = 1'b0;
      default: bus.ready = 1'b0;
    endcase
  end

  // Sweep index: parked at 0 in RUN so a sweep always starts there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      idx <= '0;
    else if (run) idx <= '0;
    else          idx <= idx + 4'd1;
  end

  // Occupancy table: sweep clears in CLEAR, placements write in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STRIPS; i++) tbl[i] <= '0;
    end else if (!run) begin
      tbl[idx] <= '0;
    end else if (wr_en) begin
      tbl[bus.min_occupied_strip_id] <= bus.new_occupied_strip_width;
    end
  end

  // Placement report, one cycle after the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.place_valid    <= 1'b0;
      bus.place_strip_id <= '0;
      bus.place_x        <= '0;
    end else begin
      bus.place_valid <= wr_en;
      if (wr_en) begin
        bus.place_strip_id <= bus.min_occupied_strip_id;
        bus.place_x        <= bus.min_occupied_strip_width;
      end
    end
  end

  // Strike pulse and saturating strike counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.strike_valid <= 1'b0;
      bus.strike_count <= '0;
    end else begin
      bus.strike_valid <= st_en;
      if (st_en && bus.strike_count != 8'hFF)
        bus.strike_count <= bus.strike_count + 8'd1;
    end
  end

  // Sticky error for dropped results; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       bus.err_flag <= 1'b0;
    else if (drop) bus.err_flag <= 1'b1;
  end

  logic [3:0] ra [3];
  logic [7:0] rw [3];

  assign ra[0] = bus.rd_id_1;
  assign ra[1] = bus.rd_id_2;
  assign ra[2] = bus.rd_id_3;

  // Reads: unknown strips look full, same-cycle writes bypass.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rw[k] = 8'hFF;
      if (ra[k] <= LAST) begin
        if (wr_en && ra[k] == bus.min_occupied_strip_id)
          rw[k] = bus.new_occupied_strip_width;
        else
          rw[k] = tbl[ra[k]];
      end
    end
  end

  assign bus.rd_width_1 = rw[0];
  assign bus.rd_width_2 = rw[1];
  assign bus.rd_width_3 = rw[2];

endmodule

// File: tb/tb_strip_width_writeback.sv
// Directed vector bench for strip_width_writeback: table-driven
// placement/strike/read vectors plus clear, saturation and reset sequences.
module tb_strip_width_writeback;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  strip_width_writeback_if bus ();

  strip_width_writeback #(
    .NUM_STRIPS(13),
    .STRIP_W(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] id;
    logic [7:0] old;
    logic       s;
    logic [7:0] nw;
    logic [3:0] r1, r2, r3;
    logic [7:0] e1, e2, e3;
    logic       epv;
    logic [3:0] epid;
    logic [7:0] epx;
    logic       esv;
    logic [7:0] esc;
    logic       eerr;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mk(
    input int v, id, old, s, nw, r1, r2, r3, e1, e2, e3,
    input int epv, epid, epx, esv, esc, eerr);
    vec_t t;
    t.v = v[0]; t.id = id[3:0]; t.old = old[7:0];
    t.s = s[0]; t.nw = nw[7:0];
    t.r1 = r1[3:0]; t.r2 = r2[3:0]; t.r3 = r3[3:0];
    t.e1 = e1[7:0]; t.e2 = e2[7:0]; t.e3 = e3[7:0];
    t.epv = epv[0]; t.epid = epid[3:0]; t.epx = epx[7:0];
    t.esv = esv[0]; t.esc = esc[7:0]; t.eerr = eerr[0];
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req)
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    else
      passed++;
  endtask

  task automatic drive(input logic v, input logic [3:0] id,
                       input logic [7:0] old, input logic s,
                       input logic [7:0] nw);
    bus.valid_in = v;
    bus.min_occupied_strip_id = id;
    bus.min_occupied_strip_width = old;
    bus.strike_flag = s;
    bus.new_occupied_strip_width = nw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] id, input logic [7:0] nw);
    drive(1'b1, id, 8'd0, 1'b0, nw);
    tick();
    drive(1'b0, 4'd0, 8'd0, 1'b0, 8'd0);
  endtask

  int n;

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    bus.clear_req = 1'b0;
    bus.rd_id_1 = 4'd0;
    bus.rd_id_2 = 4'd0;
    bus.rd_id_3 = 4'd0;
    drive(1'b0, 4'd0, 8'd0, 1'b0, 8'd0);

    vt[0] = mk(1, 3, 0, 0, 40,   3, 0, 12,  40, 0, 0,      1, 3, 0,  0, 0, 0);
    vt[1] = mk(0, 0, 0, 0, 0,    3, 14, 15, 40, 255, 255,  0, 3, 0,  0, 0, 0);
    vt[2] = mk(1, 3, 40, 0, 90,  3, 3, 0,   90, 90, 0,     1, 3, 40, 0, 0, 0);
    vt[3] = mk(1, 3, 90, 1, 200, 3, 0, 12,  90, 0, 0,      0, 3, 40, 1, 1, 0);
    vt[4] = mk(0, 0, 0, 0, 0,    3, 3, 3,   90, 90, 90,    0, 3, 40, 0, 1, 0);
    vt[5] = mk(1, 12, 0, 0, 7,   12, 11, 3, 7, 0, 90,      1, 12, 0, 0, 1, 0);
    vt[6] = mk(1, 0, 5, 0, 255,  0, 12, 3,  255, 7, 90,    1, 0, 5,  0, 1, 0);
    vt[7] = mk(1, 14, 1, 0, 50,  14, 0, 3,  255, 255, 90,  0, 0, 5,  0, 1, 1);
    vt[8] = mk(1, 13, 0, 1, 0,   13, 13, 12, 255, 255, 7,  0, 0, 5,  0, 1, 1);
    vt[9] = mk(0, 0, 0, 0, 0,    0, 12, 3,  255, 7, 90,    0, 0, 5,  0, 1, 1);

    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_ready", bus.ready, 1);
    chk("rst_place_valid", bus.place_valid, 0);
    chk("rst_strike_count", bus.strike_count, 0);
    chk("rst_err", bus.err_flag, 0);
    chk("rst_rd", bus.rd_width_1, 0);

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].v, vt[i].id, vt[i].old, vt[i].s, vt[i].nw);
      bus.rd_id_1 = vt[i].r1;
      bus.rd_id_2 = vt[i].r2;
      bus.rd_id_3 = vt[i].r3;
      #1;
      chk($sformatf("v%0d_rd1", i), bus.rd_width_1, vt[i].e1);
      chk($sformatf("v%0d_rd2", i), bus.rd_width_2, vt[i].e2);
      chk($sformatf("v%0d_rd3", i), bus.rd_width_3, vt[i].e3);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pv", i), bus.place_valid, vt[i].epv);
      chk($sformatf("v%0d_pid", i), bus.place_strip_id, vt[i].epid);
      chk($sformatf("v%0d_px", i), bus.place_x, vt[i].epx);
      chk($sformatf("v%0d_sv", i), bus.strike_valid, vt[i].esv);
      chk($sformatf("v%0d_sc", i), bus.strike_count, vt[i].esc);
      chk($sformatf("v%0d_err", i), bus.err_flag, vt[i].eerr);
    end

    // Strike saturation: count starts at 1 here.
    bus.rd_id_1 = 4'd3;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'd3, 8'd90, 1'b1, 8'd1);
      tick();
      chk($sformatf("sat%0d_sc", i), bus.strike_count,
          (i + 2 > 255) ? 255 : i + 2);
    end
    chk("sat_sv", bus.strike_valid, 1);
    drive(1'b0, 4'd0, 8'd0, 1'b0, 8'd0);
    tick();
    chk("sat_sv_off", bus.strike_valid, 0);
    chk("sat_final", bus.strike_count, 255);
    chk("sat_table", bus.rd_width_1, 90);

    // Fresh reset, then populate and sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst2_err", bus.err_flag, 0);
    chk("rst2_sc", bus.strike_count, 0);
    write(4'd1, 8'd10);
    write(4'd5, 8'd20);
    write(4'd12, 8'd30);
    bus.rd_id_1 = 4'd1;
    bus.rd_id_2 = 4'd5;
    bus.rd_id_3 = 4'd12;
    #1;
    chk("pre_clr_1", bus.rd_width_1, 10);
    chk("pre_clr_5", bus.rd_width_2, 20);
    chk("pre_clr_12", bus.rd_width_3, 30);

    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    n = 0;
    while (bus.ready === 1'b0 && n < 50) begin
      n++;
      if (n == 4) begin
        drive(1'b1, 4'd5, 8'd0, 1'b0, 8'd99);
        bus.clear_req = 1'b1;
        #1;
        chk("clr_swept_1", bus.rd_width_1, 0);
        chk("clr_nobypass_5", bus.rd_width_2, 20);
        chk("clr_unswept_12", bus.rd_width_3, 30);
      end else begin
        drive(1'b0, 4'd0, 8'd0, 1'b0, 8'd0);
        bus.clear_req = 1'b0;
      end
      if (n == 5) begin
        chk("clr_no_pulse", bus.place_valid, 0);
        chk("clr_err", bus.err_flag, 1);
      end
      tick();
    end
    drive(1'b0, 4'd0, 8'd0, 1'b0, 8'd0);
    chk("clr_busy_cycles", n, 13);
    chk("clr_ready", bus.ready, 1);
    chk("clr_done_1", bus.rd_width_1, 0);
    chk("clr_done_5", bus.rd_width_2, 0);
    chk("clr_done_12", bus.rd_width_3, 0);
    chk("clr_err_sticky", bus.err_flag, 1);
    tick();
    chk("clr_no_reclear", bus.ready, 1);

    // Asynchronous reset partway through a sweep.
    drive(1'b1, 4'd2, 8'd9, 1'b1, 8'd0);
    tick();
    drive(1'b1, 4'd10, 8'd9, 1'b0, 8'd33);
    tick();
    drive(1'b0, 4'd0, 8'd0, 1'b0, 8'd0);
    bus.rd_id_1 = 4'd10;
    #1;
    chk("ar_pre_rd", bus.rd_width_1, 33);
    chk("ar_pre_sc", bus.strike_count, 1);
    chk("ar_pre_pid", bus.place_strip_id, 10);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ar_in_clear", bus.ready, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_ready", bus.ready, 1);
    chk("ar_err", bus.err_flag, 0);
    chk("ar_sc", bus.strike_count, 0);
    chk("ar_pid", bus.place_strip_id, 0);
    chk("ar_px", bus.place_x, 0);
    chk("ar_pv", bus.place_valid, 0);
    chk("ar_sv", bus.strike_valid, 0);
    chk("ar_rd", bus.rd_width_1, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_post_ready", bus.ready, 1);
    chk("ar_post_rd", bus.rd_width_1, 0);
    tick();
    chk("ar_post_ready2", bus.ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
